// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the IN/OUT/HALT stall controller and its button debouncer.
package io_ctrl_pkg;

  localparam int unsigned SW_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_PRESS = 2'd1,
    COMMIT     = 2'd2,
    HALTED     = 2'd3
  } io_state_t;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw active-low key and emits a single-cycle pulse on each debounced press.
module button_debouncer
  import io_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;

  // Pulse is registered alongside the level update so it lands in the first cycle the new level is visible.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press_q <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/io_stall_controller.sv
// Stalls the core around IN/HALT, captures switches on a debounced press, and holds OUT data for display.
module io_stall_controller
  import io_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SW_W            = SW_W_DEF,
  parameter int unsigned DATA_W          = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              In,
  input  logic              Out,
  input  logic              Halt,
  input  logic              Button,
  input  logic [SW_W-1:0]   Switches,
  input  logic [DATA_W-1:0] OutData,
  output logic              EnableClock,
  output logic [DATA_W-1:0] InData,
  output logic              InValid,
  output logic [DATA_W-1:0] Display,
  output logic              Halted,
  output logic [1:0]        State
);

  io_state_t         state_q, state_d;
  logic              press;
  logic              enable;
  logic [DATA_W-1:0] sw_ext;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W-1:0] display_q;

  assign sw_ext = DATA_W'(Switches);

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .raw  (Button),
    .press(press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (Halt)    state_d = HALTED;
        else if (In) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: if (press) state_d = COMMIT;
      COMMIT:     state_d = RUN;
      HALTED:     state_d = HALTED;
      default:    state_d = RUN;
    endcase
  end

  // Reset gates the enable so nothing advances while the core is held.
  assign enable = reset && (((state_q == RUN) && !In && !Halt) || (state_q == COMMIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_data_q <= '0;
      display_q <= '0;
    end else begin
      if ((state_q == WAIT_PRESS) && press) in_data_q <= sw_ext;
      if (state_q == COMMIT)
        display_q <= sw_ext;
      else if ((state_q == RUN) && Out && !In && enable)
        display_q <= OutData;
    end
  end

  assign EnableClock = enable;
  assign InData      = in_data_q;
  assign InValid     = (state_q == COMMIT);
  assign Display     = display_q;
  assign Halted      = (state_q == HALTED);
  assign State       = state_q;

endmodule

// File: tb/tb_io_stall_controller.sv
// Directed bench for io_stall_controller with a scoreboard of expected IN captures.
module tb_io_stall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        In, Out, Halt, Button;
  logic [15:0] Switches;
  logic [31:0] OutData;
  logic        EnableClock;
  logic [31:0] InData;
  logic        InValid;
  logic [31:0] Display;
  logic        Halted;
  logic [1:0]  State;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  io_stall_controller #(
    .DEBOUNCE_CYCLES(4),
    .SW_W           (16),
    .DATA_W         (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .In         (In),
    .Out        (Out),
    .Halt       (Halt),
    .Button     (Button),
    .Switches   (Switches),
    .OutData    (OutData),
    .EnableClock(EnableClock),
    .InData     (InData),
    .InValid    (InValid),
    .Display    (Display),
    .Halted     (Halted),
    .State      (State)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_commit(input string tag, input int exp_n);
    int n = 0;
    while (State !== 2'd2 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  // Every commit cycle must match the oldest outstanding expected capture.
  always @(negedge clock) begin
    if (reset === 1'b1 && InValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $error("FAIL unexpected_invalid: observed InData %0h expected no commit", InData);
      end else begin
        check("scoreboard_indata", InData, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; In = 1'b0; Out = 1'b0; Halt = 1'b0; Button = 1'b1;
    Switches = '0; OutData = '0;
    repeat (3) tick();
    check("rst_enable",  32'(EnableClock), 32'd0);
    check("rst_state",   32'(State),       32'd0);
    check("rst_indata",  InData,           32'd0);
    check("rst_invalid", 32'(InValid),     32'd0);
    check("rst_display", Display,          32'd0);
    check("rst_halted",  32'(Halted),      32'd0);
    reset = 1'b1;
    tick();
    check("run_enable", 32'(EnableClock), 32'd1);
    check("run_state",  32'(State),       32'd0);

    // Basic IN: stall, debounced press, single commit with echo
    In = 1'b1; Switches = 16'hA5A5; Button = 1'b0;
    exp_q.push_back(32'h0000A5A5);
    #1;
    check("in_stall_enable", 32'(EnableClock), 32'd0);
    wait_commit("press_latency", 7);
    check("commit_enable",  32'(EnableClock), 32'd1);
    check("commit_invalid", 32'(InValid),     32'd1);
    check("commit_indata",  InData,           32'h0000A5A5);
    tick();
    In = 1'b0;
    #1;
    check("after_commit_state",  32'(State),       32'd0);
    check("after_commit_enable", 32'(EnableClock), 32'd1);
    check("echo_display",        Display,          32'h0000A5A5);
    repeat (4) tick();
    Button = 1'b1;
    repeat (8) tick();

    // Glitch shorter than the debounce window
    In = 1'b1; Button = 1'b0;
    repeat (3) tick();
    Button = 1'b1;
    repeat (15) tick();
    check("glitch_state",   32'(State),       32'd1);
    check("glitch_enable",  32'(EnableClock), 32'd0);
    check("glitch_invalid", 32'(InValid),     32'd0);

    // Back-to-back INs with the key held: second needs a fresh press
    Switches = 16'h1234; Button = 1'b0;
    exp_q.push_back(32'h00001234);
    wait_commit("held_first", 7);
    tick();
    Switches = 16'hBEEF;
    #1;
    check("b2b_run_state",  32'(State),       32'd0);
    check("b2b_run_enable", 32'(EnableClock), 32'd0);
    check("b2b_display",    Display,          32'h00001234);
    repeat (10) tick();
    check("held_wait_state", 32'(State), 32'd1);
    Button = 1'b1;
    repeat (8) tick();
    check("released_state", 32'(State), 32'd1);
    Button = 1'b0;
    exp_q.push_back(32'h0000BEEF);
    wait_commit("fresh_press", 7);

    // OUT latching and HALT priority
    tick();
    In = 1'b0; Out = 1'b1; OutData = 32'h12345678;
    #1;
    check("out_enable", 32'(EnableClock), 32'd1);
    check("b2b_echo",   Display,          32'h0000BEEF);
    tick();
    Out = 1'b0; OutData = 32'hDEADBEEF; Button = 1'b1;
    #1;
    check("out_display", Display, 32'h12345678);
    tick();
    check("out_hold", Display, 32'h12345678);
    repeat (8) tick();
    Halt = 1'b1; In = 1'b1;
    #1;
    check("halt_stall_enable", 32'(EnableClock), 32'd0);
    tick();
    Halt = 1'b0; In = 1'b0;
    #1;
    check("halt_state",  32'(State),       32'd3);
    check("halted",      32'(Halted),      32'd1);
    check("halt_enable", 32'(EnableClock), 32'd0);
    Button = 1'b0; Switches = 16'h5555;
    repeat (12) tick();
    Button = 1'b1;
    repeat (8) tick();
    check("halt_parked",  32'(State),  32'd3);
    check("halt_indata",  InData,      32'h0000BEEF);
    check("halt_display", Display,     32'h12345678);

    // Reset out of HALTED, then reset mid-debounce
    reset = 1'b0;
    #1;
    check("exit_halt_state",  32'(State),  32'd0);
    check("exit_halt_indata", InData,      32'd0);
    check("exit_halted",      32'(Halted), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    In = 1'b1; Switches = 16'h0F0F; Button = 1'b0;
    exp_q.push_back(32'h00000F0F);
    wait_commit("post_reset_press", 7);
    tick();
    In = 1'b0; Button = 1'b1;
    repeat (8) tick();
    In = 1'b1; Button = 1'b0;
    repeat (4) tick();
    check("partial_state",  32'(State), 32'd1);
    check("partial_indata", InData,     32'h00000F0F);
    reset = 1'b0; Button = 1'b1;
    #1;
    check("mid_reset_state",  32'(State),       32'd0);
    check("mid_reset_indata", InData,           32'd0);
    check("mid_reset_enable", 32'(EnableClock), 32'd0);
    tick();
    reset = 1'b1; Button = 1'b0;
    repeat (3) tick();
    Button = 1'b1;
    repeat (12) tick();
    check("post_glitch_state",  32'(State), 32'd1);
    check("post_glitch_indata", InData,     32'd0);
    Switches = 16'h00C3; Button = 1'b0;
    exp_q.push_back(32'h000000C3);
    wait_commit("final_press", 7);
    tick();
    In = 1'b0;
    #1;
    check("final_display", Display, 32'h000000C3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/io_stall_controller.md
Name: io_stall_controller

Overview:
Sequences processor advance around the control unit's In/Out/Halt decode.
- Drives the global EnableClock that gates PC and register-file updates.
- Stalls on IN until a debounced Button press, then captures the switches and releases exactly one commit cycle.
- Latches OUT data for the display and parks the core on HALT.
- Sits between the control unit, board I/O (KEY/SW/7-seg driver) and the datapath write-back mux.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized cycles required to accept a new Button level (min 2)
SW_W, 16, switch input width
DATA_W, 32, datapath word width (SW_W <= DATA_W)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
In  input  1  control-unit IN decode
Out  input  1  control-unit OUT decode (also asserted with IN)
Halt  input  1  control-unit HALT decode
Button  input  1  raw board key, active-low (0 = pressed), asynchronous
Switches  input  SW_W  raw board switches
OutData  input  DATA_W  register value presented by datapath for OUT
EnableClock  output  1  processor advance enable
InData  output  DATA_W  captured switches, zero-extended, to write-back mux
InValid  output  1  one-cycle pulse in the commit cycle of an IN
Display  output  DATA_W  value held for 7-seg driver
Halted  output  1  core parked by HALT
State  output  2  FSM state for debug

Behaviour:
- Reset (async, reset=0): State=RUN, InData=0, InValid=0, Display=0, Halted=0, debouncer counter=0, debounced level=1 (released). EnableClock forced 0 while reset=0.
- Button path: 2-FF synchronizer, then debouncer.
  - Counter clears whenever synced == debounced; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 while still differing: debounced <= synced, counter <= 0.
  - PressEvent = one-cycle pulse on debounced 1->0.
  - Latency from raw press to PressEvent = 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- FSM encoding: RUN=0, WAIT_PRESS=1, COMMIT=2, HALTED=3.
  - RUN: if Halt -> HALTED; else if In -> WAIT_PRESS; else stay. Halt has priority over In.
  - WAIT_PRESS: on PressEvent, InData <= zero-extended Switches and go to COMMIT; otherwise stay.
  - COMMIT: unconditionally -> RUN. InValid=1 in this cycle only.
  - HALTED: terminal; only reset exits.
- EnableClock (combinational) = (State==RUN && !In && !Halt) || State==COMMIT.
  - An IN or HALT instruction is stalled in the same cycle it is decoded.
  - The IN instruction commits in the COMMIT cycle, while In is still asserted.
- Press handling: edge-based, never level-based.
  - A key held from one IN into the next does not satisfy the second; a fresh press is required.
  - PressEvents in RUN, COMMIT or HALTED are dropped, not queued.
- Display:
  - Display <= OutData on the edge ending a cycle with State==RUN && Out && !In && EnableClock.
  - Display <= Switches zero-extended (the value being committed) on the edge ending COMMIT, i.e. IN echoes to the display.
  - No update in any other cycle.
- Halted = (State==HALTED), registered via the state flop.
- Reset mid-operation: from any state return to RUN. A pending capture is discarded and InData clears.
- Switches are sampled only on the PressEvent edge and are not synchronized. Operators must hold switches stable while pressing.

Decomposition:
- Package io_ctrl_pkg: state encodings (RUN/WAIT_PRESS/COMMIT/HALTED as 2-bit localparams), default SW_W/DATA_W, and a function computing the counter width from DEBOUNCE_CYCLES.
- One sub-module, button_debouncer (synchronizer + counter + press-pulse). It is reusable for other board keys.
- FSM, capture and display registers stay in the top.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset held, then released with In=0, Halt=0 -> all outputs 0 during reset; EnableClock=1 and State=0 from the first cycle after release.
2. In=1, Switches=16'hA5A5, Button low for 12 cycles -> EnableClock=0 from the In cycle; PressEvent 6 cycles after press; next cycle State=2, EnableClock=1, InValid=1, InData=32'h0000A5A5, Display=32'h0000A5A5 after that edge; then State=0.
3. In=1, Button low 3 cycles then high -> no PressEvent; State stays 1; EnableClock stays 0 indefinitely.
4. Two back-to-back INs with Button held low throughout -> first commits; second stays in WAIT_PRESS until Button is released ≥4 cycles and pressed again.
5. Out=1, OutData=32'h12345678 in RUN -> Display=32'h12345678 next edge. Halt=1 with In=1 simultaneously -> State=3, Halted=1, EnableClock=0; later presses ignored.
6. Assert reset while State=1 (after partial debounce) -> immediately State=0, InData=0, debouncer cleared; after release a 3-cycle Button glitch produces no event.
